dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the 5-stage MIPS pipeline. Sits on the CPU's MEM-stage port (mem_ren, mem_wen, mem_addr, mem_dout in; mem_din out) and serves word reads and writes from an internal RAM with a fixed, parameterizable number of wait states. Raises a combinational stall so the pipeline controller can freeze the stage enables until the access completes.

## Interface
- ADDR_WIDTH, 8: word-address bits; RAM depth is 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2: extra wait states per access; legal range 0..15.
- clk  in  1  main clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_ren  in  1  read request from the CPU MEM stage.
- mem_wen  in  1  write request from the CPU MEM stage.
- mem_addr  in  32  byte address; held stable by the CPU while mem_stall=1.
- mem_dout  in  32  write data from the CPU; held stable while mem_stall=1.
- mem_din  out  32  read data to the CPU; valid only in the DONE cycle.
- mem_stall  out  1  combinational; 1 while an accepted access is incomplete.
- mem_ack  out  1  one-cycle pulse in the cycle the access completes (DONE).
- mem_err  out  1  valid with mem_ack; 1 = misaligned, out-of-range, or ren&wen both set.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state IDLE.
- IDLE, no request: mem_stall=0, mem_ack=0, mem_din=0.
- IDLE, request (ren|wen): capture addr, write data, kind and error flag; mem_stall=1 in the same cycle. Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go straight to DONE.
- WAIT: mem_stall=1; counter decrements each cycle; at counter=0 go to DONE.
- Commit edge (the edge entering DONE): write performs the RAM write at word index addr[ADDR_WIDTH+1:2]; read latches the RAM word into the read register.
- DONE: mem_stall=0, mem_ack=1, mem_din=read register (0 for writes and errors), mem_err valid. Always return to IDLE next cycle.
- Error conditions:
  - addr[1:0]≠0 or addr[31:ADDR_WIDTH+2]≠0: no RAM access; read data 0; mem_err=1.
  - ren&wen both set: treated as a write; mem_err=1.
- Back-to-back accesses: a new request appearing in the IDLE cycle after DONE starts a fresh access. There is no pipelining of requests.
- Requests are ignored in WAIT and DONE (the CPU holds them stable). Captured values are used, not the live inputs.

## Timing
- Request first seen in IDLE at cycle T:
  - mem_stall=1 for cycles T..T+WAIT_CYCLES.
  - DONE at cycle T+WAIT_CYCLES+1.
  - Total occupancy WAIT_CYCLES+2 cycles.
- The CPU advances the MEM/WB registers at the DONE-cycle edge and captures mem_din there.
- Reset (asserted at any time, including mid-access): FSM→IDLE; counter, read register and error flag cleared; mem_din=0, mem_stall=0, mem_ack=0, mem_err=0 while rst=1. A pending write that has not reached its commit edge is dropped. RAM contents are not cleared.
- Counter is 4 bits. WAIT_CYCLES>15 is illegal and must fail an elaboration-time check.

## Structure
- FSM state encodings (IDLE/WAIT/DONE, 2 bits) go in the shared define.vh header alongside the existing pipeline constants.
- One sub-module: dmem_ram, a single-port synchronous RAM (ADDR_WIDTH, 32-bit data, write enable, registered read, no reset).
- The FSM, counter, capture registers and error decode live in dmem_responder.

## Test plan
- WAIT_CYCLES=2, write 0xDEADBEEF to 0x10, then read 0x10.
  - Write: stall high 3 cycles, ack in the 4th.
  - Read: mem_din=0xDEADBEEF in its DONE cycle, mem_err=0.
- WAIT_CYCLES=0, read 0x04 after writing 0x12345678.
  - Stall high exactly 1 cycle, ack the next cycle with mem_din=0x12345678.
- Misaligned write to 0x11, then out-of-range read of 0x400 (ADDR_WIDTH=8).
  - Both ack with mem_err=1; the read returns 0.
  - A following read of 0x10 still returns the earlier value (no RAM change).
- ren=wen=1 to 0x20 with data 0xA5A5A5A5: mem_err=1 in DONE; a later read of 0x20 returns 0xA5A5A5A5.
- Write 0x0BADF00D to 0x30 with rst pulsed during WAIT (before the commit edge).
  - All outputs 0 during rst; FSM in IDLE after.
  - A subsequent read of 0x30 returns its prior value.
- Back-to-back read 0x10 then write 0x14.
  - Second access begins in the IDLE cycle immediately after the first ack.
  - Total 2×(WAIT_CYCLES+2) cycles, no lost or duplicated ack.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Holds the FSM state encoding, the wait-counter width and the address decode.
package dmem_responder_pkg;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Misaligned or beyond the RAM's word range: the access never touches RAM.
  function automatic logic addr_bad(input logic [31:0] a, input int aw);
    logic [31:0] hi;
    hi = a >> (aw + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with registered read and no reset.
module dmem_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the CPU MEM-stage port: fixed wait states per word
// access, combinational stall, one-cycle ack with error flag and read data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    wr_q, bad_q, err_q, rd_ok_q;

  logic                    req, idle, commit, done;
  logic                    wr_e, bad_e, bad_live;
  logic [ADDR_WIDTH-1:0]   idx_e;
  logic [31:0]             wdata_e, ram_rdata;

  assign req      = mem_ren | mem_wen;
  assign idle     = (state_q == ST_IDLE);
  assign bad_live = addr_bad(mem_addr, ADDR_WIDTH);

  // With zero wait states the commit edge is the capture edge, so the live
  // inputs must drive the RAM while idle; afterwards the captured copy does.
  assign idx_e   = idle ? mem_addr[ADDR_WIDTH+1:2] : idx_q;
  assign wdata_e = idle ? mem_dout : wdata_q;
  assign wr_e    = idle ? mem_wen  : wr_q;
  assign bad_e   = idle ? bad_live : bad_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        if (WAIT_CYCLES == 0) state_d = ST_DONE;
        else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      ST_WAIT: if (cnt_q == '0) state_d = ST_DONE;
               else cnt_d = cnt_q - 1'b1;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        idx_q   <= mem_addr[ADDR_WIDTH+1:2];
        wdata_q <= mem_dout;
        wr_q    <= mem_wen;
        bad_q   <= bad_live;
        err_q   <= bad_live | (mem_ren & mem_wen);
      end
      rd_ok_q <= commit & ~wr_e & ~bad_e;
    end
  end

  // The RAM output register doubles as the read register; rd_ok_q qualifies it.
  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we_i    (commit & wr_e & ~bad_e),
    .addr_i  (idx_e),
    .wdata_i (wdata_e),
    .rdata_o (ram_rdata)
  );

  assign done      = ~rst & (state_q == ST_DONE);
  assign mem_stall = ~rst & ((idle & req) | (state_q == ST_WAIT));
  assign mem_ack   = done;
  assign mem_err   = done & err_q;
  assign mem_din   = (done & rd_ok_q) ? ram_rdata : 32'd0;

endmodule
